mem_responder: RTL and testbench

- Pipelined memory server: the responder end of the MemIntf val/rdy request/response protocol used by execute-unit memory clients (load/store units, fetch).
- Accepts one request per cycle, performs a word-granular read or byte-strobed write on an internal word array, and returns a response after a fixed latency.
- Backpressure from the client is absorbed in a response FIFO and a credit counter, so requests are never lost.
- Used as the simulation/FPGA data memory behind client units.

---
 rtl/mem_responder_if.sv | 35 +++
 rtl/mem_responder.sv | 148 ++++++++++++++
 tb/tb_mem_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response channel between a memory client (master) and the memory
// responder (slave): val/rdy handshake on each direction with echoed payload.
interface mem_responder_if #(
  parameter int p_opaq_bits = 8
);
  logic                   req_val;
  logic                   req_rdy;
  logic                   req_msg_op;
  logic [p_opaq_bits-1:0] req_msg_opaque;
  logic [31:0]            req_msg_addr;
  logic [3:0]             req_msg_strb;
  logic [31:0]            req_msg_data;

  logic                   resp_val;
  logic                   resp_rdy;
  logic                   resp_msg_op;
  logic [p_opaq_bits-1:0] resp_msg_opaque;
  logic [31:0]            resp_msg_addr;
  logic [3:0]             resp_msg_strb;
  logic [31:0]            resp_msg_data;

  modport master (
    output req_val, req_msg_op, req_msg_opaque, req_msg_addr, req_msg_strb, req_msg_data,
    input  req_rdy,
    input  resp_val, resp_msg_op, resp_msg_opaque, resp_msg_addr, resp_msg_strb, resp_msg_data,
    output resp_rdy
  );

  modport slave (
    input  req_val, req_msg_op, req_msg_opaque, req_msg_addr, req_msg_strb, req_msg_data,
    output req_rdy,
    output resp_val, resp_msg_op, resp_msg_opaque, resp_msg_addr, resp_msg_strb, resp_msg_data,
    input  resp_rdy
  );
endinterface

// File: rtl/mem_responder.sv
// Pipelined word-array memory server: accepts one request per cycle, answers after
// a fixed latency, and buffers responses in a FIFO guarded by a credit counter.
module mem_responder #(
  parameter int p_opaq_bits  = 8,
  parameter int p_mem_words  = 256,
  parameter int p_latency    = 2,
  parameter int p_resp_depth = 4
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave mem
);
  localparam int   AW       = $clog2(p_mem_words);
  localparam int   CW       = $clog2(p_resp_depth + 1);
  localparam int   PW       = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
  localparam logic OP_WRITE = 1'b1;

  typedef struct packed {
    logic                   op;
    logic [p_opaq_bits-1:0] opaque;
    logic [31:0]            addr;
    logic [3:0]             strb;
    logic [31:0]            data;
  } resp_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_resp_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [31:0]   mem_q [p_mem_words];
  logic [CW-1:0] credit_q;
  logic          acc_p0;
  logic          is_wr_p0;
  logic [AW-1:0] idx_p0;
  resp_t         msg_p0;
  resp_t         enq_msg_p2;
  logic          enq_vld_p2;
  logic          deq;

  // ---- p0: accept stage, array access at the accept edge ----
  // rdy looks only at the registered credit count, never at req_val.
  assign mem.req_rdy = (credit_q < CW'(p_resp_depth));
  assign acc_p0      = mem.req_val && mem.req_rdy && !rst;
  assign idx_p0      = mem.req_msg_addr[AW+1:2];
  assign is_wr_p0    = (mem.req_msg_op == OP_WRITE);

  always_comb begin
    msg_p0.op     = mem.req_msg_op;
    msg_p0.opaque = mem.req_msg_opaque;
    msg_p0.addr   = mem.req_msg_addr;
    msg_p0.strb   = mem.req_msg_strb;
    msg_p0.data   = is_wr_p0 ? 32'd0 : mem_q[idx_p0];
  end

  always_ff @(posedge clk) begin
    if (acc_p0 && is_wr_p0)
      mem_q[idx_p0] <= merge_bytes(mem_q[idx_p0], mem.req_msg_data, mem.req_msg_strb);
  end

  always_ff @(posedge clk) begin
    if (rst)
      credit_q <= '0;
    else if (acc_p0 && !deq)
      credit_q <= credit_q + CW'(1);
    else if (!acc_p0 && deq)
      credit_q <= credit_q - CW'(1);
  end

  // ---- p1: fixed delay line; the FIFO write is the final latency cycle ----
  generate
    if (p_latency == 1) begin : g_direct
      assign enq_msg_p2 = msg_p0;
      assign enq_vld_p2 = acc_p0;
    end else begin : g_delay
      resp_t msg_p1 [p_latency-1];
      logic  vld_p1 [p_latency-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < p_latency - 1; i++) vld_p1[i] <= 1'b0;
        end else begin
          vld_p1[0] <= acc_p0;
          for (int i = 1; i < p_latency - 1; i++) vld_p1[i] <= vld_p1[i-1];
        end
      end

      always_ff @(posedge clk) begin
        msg_p1[0] <= msg_p0;
        for (int i = 1; i < p_latency - 1; i++) msg_p1[i] <= msg_p1[i-1];
      end

      assign enq_msg_p2 = msg_p1[p_latency-2];
      assign enq_vld_p2 = vld_p1[p_latency-2];
    end
  endgenerate

  // ---- p2: response FIFO; credits bound occupancy so enqueue never blocks ----
  resp_t         fifo_q [p_resp_depth];
  resp_t         head;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] occ_q;

  assign head         = fifo_q[rd_ptr_q];
  assign mem.resp_val = (occ_q != '0);
  assign deq          = mem.resp_val && mem.resp_rdy;

  assign mem.resp_msg_op     = head.op;
  assign mem.resp_msg_opaque = head.opaque;
  assign mem.resp_msg_addr   = head.addr;
  assign mem.resp_msg_strb   = head.strb;
  assign mem.resp_msg_data   = head.data;

  always_ff @(posedge clk) begin
    if (enq_vld_p2) fifo_q[wr_ptr_q] <= enq_msg_p2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (enq_vld_p2) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (deq)        rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({enq_vld_p2, deq})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_occ_le_credit: assert property (@(posedge clk) disable iff (rst) occ_q <= credit_q);
  a_credit_range:  assert property (@(posedge clk) disable iff (rst) credit_q <= CW'(p_resp_depth));
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a word-array reference model predicts each
// response at issue time; a negedge monitor pops and compares on every dequeue.
module tb_mem_responder;
  localparam int P_OPQ   = 8;
  localparam int P_WORDS = 256;
  localparam int P_LAT   = 2;
  localparam int P_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if #(.p_opaq_bits(P_OPQ)) mif ();

  mem_responder #(
    .p_opaq_bits (P_OPQ),
    .p_mem_words (P_WORDS),
    .p_latency   (P_LAT),
    .p_resp_depth(P_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem(mif.slave)
  );

  typedef struct {
    logic             op;
    logic [P_OPQ-1:0] opq;
    logic [31:0]      addr;
    logic [3:0]       strb;
    logic [31:0]      data;
    int               cyc;
    bit               exact;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [P_WORDS];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_deq = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: in-order word array, applied when a request is accepted.
  task automatic record(input logic op, input logic [P_OPQ-1:0] opq, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] data, input bit exact);
    exp_t e;
    int   idx;
    idx    = int'((addr >> 2) % P_WORDS);
    e.op   = op;
    e.opq  = opq;
    e.addr = addr;
    e.strb = strb;
    if (op) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
      e.data = 32'd0;
    end else begin
      e.data = model_mem[idx];
    end
    e.cyc   = cyc;
    e.exact = exact;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic val, input logic op, input logic [P_OPQ-1:0] opq,
                       input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
    mif.req_val        = val;
    mif.req_msg_op     = op;
    mif.req_msg_opaque = opq;
    mif.req_msg_addr   = addr;
    mif.req_msg_strb   = strb;
    mif.req_msg_data   = data;
  endtask

  // One cycle of request drive; called at posedge+1, returns at the next posedge+1.
  task automatic try_once(input logic val, input logic op, input logic [P_OPQ-1:0] opq,
                          input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] data, input bit exact, output bit acc);
    drive(val, op, opq, addr, strb, data);
    acc = val && mif.req_rdy;
    if (acc) record(op, opq, addr, strb, data, exact);
    @(posedge clk); #1;
    mif.req_val = 1'b0;
  endtask

  task automatic send(input logic op, input logic [P_OPQ-1:0] opq, input logic [31:0] addr,
                      input logic [3:0] strb, input logic [31:0] data, input bit exact,
                      output int stalls);
    bit acc;
    stalls = 0;
    acc    = 1'b0;
    while (!acc && stalls < 100) begin
      try_once(1'b1, op, opq, addr, strb, data, exact, acc);
      if (!acc) stalls++;
    end
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: request addr %h never accepted", addr);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      n_acc <= 0;
      n_deq <= 0;
    end else begin
      if (mif.req_val && mif.req_rdy)   n_acc <= n_acc + 1;
      if (mif.resp_val && mif.resp_rdy) n_deq <= n_deq + 1;
    end
  end

  // Monitor: credit rule every cycle, scoreboard compare on every dequeue.
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_rdy_credit", mif.req_rdy, ((n_acc - n_deq) < P_DEPTH) ? 1 : 0);
      if (mif.resp_val && mif.resp_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp_addr", mif.resp_msg_addr, 32'hxxxxxxxx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_op",     mif.resp_msg_op,     e.op);
          chk("resp_opaque", mif.resp_msg_opaque, e.opq);
          chk("resp_addr",   mif.resp_msg_addr,   e.addr);
          chk("resp_strb",   mif.resp_msg_strb,   e.strb);
          chk("resp_data",   mif.resp_msg_data,   e.data);
          if (e.exact) chk("resp_latency", cyc, e.cyc + P_LAT);
          else         chk("resp_latency_min", (cyc >= e.cyc + P_LAT) ? 1 : 0, 1);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int accs;
    bit acc;

    rst = 1'b1;
    mif.resp_rdy = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_resp_val", mif.resp_val, 0);
    chk("reset_req_rdy",  mif.req_rdy,  1);

    // Fill the array so every later read has a known model value.
    for (int w = 0; w < P_WORDS; w++)
      send(1'b1, P_OPQ'(w), 32'(w * 4), 4'hF, $urandom(), 1'b1, stalls);

    send(1'b1, 8'h11, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, stalls);
    send(1'b0, 8'h22, 32'h10, 4'h0, 32'h0,        1'b1, stalls);
    send(1'b1, 8'h33, 32'h10, 4'h2, 32'h0000AB00, 1'b1, stalls);
    send(1'b0, 8'h44, 32'h13, 4'h0, 32'h0,        1'b1, stalls);
    drain();
    chk("model_partial_word", model_mem[4], 32'hDEADABEF);

    accs = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, P_OPQ'(i), 32'(i * 4), 4'hF, 32'h0, 1'b1, stalls);
      accs += stalls;
    end
    chk("b2b_stalls", accs, 0);
    drain();

    mif.resp_rdy = 1'b0;
    accs = 0;
    for (int i = 0; i < 8; i++) begin
      try_once(1'b1, 1'b0, P_OPQ'(8'h80 + i), 32'(i * 8), 4'hF, 32'h0, 1'b0, acc);
      if (acc) accs++;
    end
    chk("bp_accepts", accs, 4);
    chk("bp_req_rdy_low", mif.req_rdy, 0);
    mif.resp_rdy = 1'b1;
    chk("bp_rdy_low_at_first_deq", mif.req_rdy, 0);
    @(posedge clk); #1;
    chk("bp_rdy_after_deq", mif.req_rdy, 1);
    drain();

    send(1'b1, 8'h55, 32'h400, 4'hF, 32'h12345678, 1'b1, stalls);
    send(1'b0, 8'h66, 32'h0,   4'hF, 32'h0,        1'b1, stalls);
    drain();

    mif.resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      send(1'b0, P_OPQ'(8'hA0 + i), 32'(i * 4), 4'hF, 32'h0, 1'b0, stalls);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    mif.resp_rdy = 1'b1;
    chk("midrst_resp_val", mif.resp_val, 0);
    chk("midrst_req_rdy",  mif.req_rdy,  1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale_resp", mif.resp_val, 0);
    end
    send(1'b0, 8'hB0, 32'h10, 4'hF, 32'h0, 1'b1, stalls);
    drain();

    for (int i = 0; i < 400; i++) begin
      mif.resp_rdy = ($urandom_range(0, 99) < 60);
      try_once(($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)), P_OPQ'($urandom()),
               $urandom(), 4'($urandom()), $urandom(), 1'b0, acc);
    end
    mif.resp_rdy = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
